// File: rtl/filter_pkg.sv
// filter_pkg: shared constants, feeder state encoding and window byte-pack helpers
package filter_pkg;
  localparam int PIX_W = 8;
  localparam int NTAPS = 8;
  localparam int LPAD = NTAPS / 2 - 1;
  localparam int RPAD = NTAPS / 2;
  localparam int WIN_W = NTAPS * PIX_W;
  localparam int CNT_W = $clog2(RPAD + 1);
  localparam logic [CNT_W-1:0] RPAD_C = CNT_W'(RPAD);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  function automatic logic [PIX_W-1:0] win_byte(input logic [WIN_W-1:0] w, input int j);
    return w[j*PIX_W +: PIX_W];
  endfunction
  function automatic logic [WIN_W-1:0] win_shift(input logic [WIN_W-1:0] w, input logic [PIX_W-1:0] p);
    return {p, w[WIN_W-1:PIX_W]};
  endfunction
endpackage

// File: rtl/filter_tap_window.sv
// filter_tap_window: NTAPS-deep sample register with load-all and shift-in, packed byte j = tap j
module filter_tap_window
  import filter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PIX_W-1:0] din,
  output logic [WIN_W-1:0] taps
);
  logic [WIN_W-1:0] taps_q, taps_d;
  always_comb taps_d = load ? {NTAPS{din}} : shift ? win_shift(taps_q, din) : taps_q;
  always_ff @(posedge clk) taps_q <= rst ? '0 : taps_d;
  assign taps = taps_q;
endmodule

// File: rtl/filter_line_feeder.sv
// filter_line_feeder: streams one edge-replicated NTAPS-sample window per pixel of each input line
module filter_line_feeder
  import filter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_last,
  output logic             pix_ready,
  output logic [WIN_W-1:0] win_pix,
  output logic             win_valid,
  output logic             win_first,
  output logic             win_last,
  input  logic             win_ready
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] s_q, s_d, f_q, f_d, s_inc, f_inc;
  logic emitted_q, emitted_d;
  logic [WIN_W-1:0] win_pix_q, win_pix_d, taps;
  logic win_valid_q, win_valid_d, win_first_q, win_first_d, win_last_q, win_last_d;
  logic adv, acc, load, shift, emit, flush_end;
  logic [PIX_W-1:0] shift_in;
  filter_tap_window u_taps (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .shift(shift),
    .din  (shift_in),
    .taps (taps)
  );
  always_comb begin
    adv = !win_valid_q || win_ready;
    pix_ready = !rst && adv && state_q != FLUSH;
    acc = pix_valid && pix_ready;
    load = acc && state_q == IDLE;
    shift = state_q == FLUSH ? adv : acc && state_q == RUN;
    shift_in = state_q == FLUSH ? win_byte(taps, NTAPS - 1) : pix_in;
    s_inc = s_q == RPAD_C ? s_q : s_q + CNT_W'(1);
    f_inc = f_q + CNT_W'(1);
    emit = shift && s_inc == RPAD_C;
    flush_end = shift && state_q == FLUSH && f_inc == RPAD_C;
    s_d = load ? '0 : shift ? s_inc : s_q;
    f_d = state_q != FLUSH ? '0 : shift ? f_inc : f_q;
    emitted_d = load ? 1'b0 : emitted_q || emit;
    state_d = load ? (pix_last ? FLUSH : RUN) : acc && pix_last ? FLUSH : flush_end ? IDLE : state_q;
    win_valid_d = adv ? emit : win_valid_q;
    win_first_d = adv ? emit && !emitted_q : win_first_q;
    win_last_d = adv ? emit && flush_end : win_last_q;
    win_pix_d = emit ? win_shift(taps, shift_in) : win_pix_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q <= '0;
      f_q <= '0;
      emitted_q <= 1'b0;
      win_pix_q <= '0;
      win_valid_q <= 1'b0;
      win_first_q <= 1'b0;
      win_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      f_q <= f_d;
      emitted_q <= emitted_d;
      win_pix_q <= win_pix_d;
      win_valid_q <= win_valid_d;
      win_first_q <= win_first_d;
      win_last_q <= win_last_d;
    end
  end
  assign win_pix = win_pix_q;
  assign win_valid = win_valid_q;
  assign win_first = win_first_q;
  assign win_last = win_last_q;
endmodule
